// File: rtl/alu_arb_32.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight; results are held until the response handshake completes.
module alu_arb_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic               gnt;

    function automatic logic legal_op(input logic [3:0] op);
        return (op <= 4'd4) || ((op >= 4'd8) && (op <= 4'd12));
    endfunction

    // Arbitration, capture and sequencing of the single in-flight operation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        res_d      = res_q;
        zero_d     = zero_q;
        err_d      = err_q;
        gnt        = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_ctrl   = 4'd0;
        alu_a      = '0;
        alu_b      = '0;
        unique case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    gnt        = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
                    req0_ready = ~gnt;
                    req1_ready = gnt;
                    op_d       = gnt ? req1_op : req0_op;
                    a_d        = gnt ? req1_a  : req0_a;
                    b_d        = gnt ? req1_b  : req0_b;
                    id_d       = gnt;
                    rr_ptr_d   = ~gnt;
                    if (legal_op(op_d)) begin
                        state_d = EXEC;
                    end else begin
                        res_d   = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                alu_ctrl = op_q;
                alu_a    = a_q;
                alu_b    = b_q;
                res_d    = alu_result;
                zero_d   = alu_zero;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            op_q     <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arb_32.sv
// Bench for alu_arb_32: transaction-level reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_alu_arb_32;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = 4'd0, req1_op = 4'd0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
    logic [W-1:0] rsp_result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arb_32 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return W'($signed(a) >>> b[4:0]);
            4'd11:   return W'($signed(a) < $signed(b));
            4'd12:   return W'(a < b);
            default: return '0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return (op inside {[4'd0:4'd4], [4'd8:4'd12]});
    endfunction

    // Shared ALU provided by the bench.
    assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: abstract phase flags and the expected response contents.
    bit           m_exec = 0, m_resp = 0;
    int           m_rr = 0;
    int           e_id = 0;
    logic [3:0]   e_op = '0;
    logic [W-1:0] e_a = '0, e_b = '0, e_res = '0;
    bit           e_zero = 0, e_err = 0;

    function automatic int pick(input logic v0, input logic v1, input int rr);
        if (v0 && v1) return rr;
        return v1 ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exec = 0; m_resp = 0; m_rr = 0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp = 0;
        end else if (m_exec) begin
            m_exec = 0; m_resp = 1;
        end else if (req0_valid || req1_valid) begin
            e_id = pick(req0_valid, req1_valid, m_rr);
            m_rr = 1 - e_id;
            e_op = e_id ? req1_op : req0_op;
            e_a  = e_id ? req1_a  : req0_a;
            e_b  = e_id ? req1_b  : req0_b;
            if (is_legal(e_op)) begin
                e_res = alu_f(e_op, e_a, e_b); e_zero = (e_res == '0); e_err = 0; m_exec = 1;
            end else begin
                e_res = '0; e_zero = 0; e_err = 1; m_resp = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit idle;
        int g;
        idle = rst_n && !m_exec && !m_resp;
        g = pick(req0_valid, req1_valid, m_rr);
        chk("req0_ready", W'(req0_ready), W'(idle && (req0_valid || req1_valid) && g == 0));
        chk("req1_ready", W'(req1_ready), W'(idle && (req0_valid || req1_valid) && g == 1));
        chk("alu_ctrl", W'(alu_ctrl), (rst_n && m_exec) ? W'(e_op) : '0);
        chk("alu_a", alu_a, (rst_n && m_exec) ? e_a : '0);
        chk("alu_b", alu_b, (rst_n && m_exec) ? e_b : '0);
        chk("rsp_valid", W'(rsp_valid), W'(rst_n && m_resp));
        if (!rst_n) begin
            chk("rst_rsp_id", W'(rsp_id), '0);
            chk("rst_rsp_result", rsp_result, '0);
            chk("rst_rsp_zero", W'(rsp_zero), '0);
            chk("rst_rsp_err", W'(rsp_err), '0);
        end else if (m_resp) begin
            chk("rsp_id", W'(rsp_id), W'(e_id));
            chk("rsp_result", rsp_result, e_res);
            chk("rsp_zero", W'(rsp_zero), W'(e_zero));
            chk("rsp_err", W'(rsp_err), W'(e_err));
        end
    end

    logic         r_id[8];
    logic [W-1:0] r_res[8];
    logic         r_zero[8];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requesters hold valid until their remaining operation counts reach zero.
    task automatic run_ops(input int n0, input int n1, input int nrsp);
        int got = 0, cyc = 0, l0 = n0, l1 = n1;
        rsp_ready = 1'b1;
        req0_valid = (l0 > 0); req1_valid = (l1 > 0);
        while (got < nrsp && cyc < 200) begin
            @(negedge clk);
            if (req0_ready) l0--;
            if (req1_ready) l1--;
            if (rsp_valid) begin
                r_id[got] = rsp_id; r_res[got] = rsp_result; r_zero[got] = rsp_zero; got++;
            end
            step();
            req0_valid = (l0 > 0); req1_valid = (l1 > 0);
            cyc++;
        end
        chk("run_ops_timeout", W'(got), W'(nrsp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge clk);
        chk("reset_rsp_valid", W'(rsp_valid), '0);
        chk("reset_alu_ctrl", W'(alu_ctrl), '0);
        do_reset();

        // req0 ADD 5+7
        req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        @(negedge clk); chk("add_ready", W'(req0_ready), 32'd1);
        step(); req0_valid = 1'b0;
        @(negedge clk); chk("add_exec_ctrl", W'(alu_ctrl), 32'd0); chk("add_exec_a", alu_a, 32'd5);
        chk("add_exec_valid", W'(rsp_valid), 32'd0);
        step();
        @(negedge clk); chk("add_valid", W'(rsp_valid), 32'd1); chk("add_id", W'(rsp_id), 32'd0);
        chk("add_result", rsp_result, 32'd12); chk("add_zero", W'(rsp_zero), 32'd0);
        step();

        // Both valid after reset: req0 first, then req1
        do_reset();
        req0_op = 4'd1; req0_a = 32'd9;    req0_b = 32'd9;
        req1_op = 4'd3; req1_a = 32'hF0;   req1_b = 32'h0F;
        run_ops(1, 1, 2);
        chk("both_first_id", W'(r_id[0]), 32'd0); chk("both_first_res", r_res[0], 32'd0);
        chk("both_first_zero", W'(r_zero[0]), 32'd1);
        chk("both_second_id", W'(r_id[1]), 32'd1); chk("both_second_res", r_res[1], 32'hFF);

        // req1 SLTU with back-pressure; req0 waits behind it
        do_reset();
        rsp_ready = 1'b0;
        req1_op = 4'd12; req1_a = 32'd1; req1_b = 32'hFFFF_FFFF; req1_valid = 1'b1;
        @(negedge clk); chk("sltu_ready", W'(req1_ready), 32'd1);
        step(); req1_valid = 1'b0;
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        @(negedge clk); chk("sltu_exec_no_ready", W'(req0_ready), 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("sltu_hold_valid", W'(rsp_valid), 32'd1); chk("sltu_hold_res", rsp_result, 32'd1);
            chk("sltu_hold_id", W'(rsp_id), 32'd1); chk("sltu_hold_no_ready", W'(req0_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk); chk("sltu_hs_valid", W'(rsp_valid), 32'd1);
        chk("sltu_hs_no_ready", W'(req0_ready), 32'd0);
        step();
        @(negedge clk); chk("after_hs_ready", W'(req0_ready), 32'd1);
        step(); req0_valid = 1'b0;
        repeat (4) step();

        // Illegal op 13
        req0_op = 4'd13; req0_a = 32'd3; req0_b = 32'd4; req0_valid = 1'b1;
        @(negedge clk); chk("ill_ready", W'(req0_ready), 32'd1);
        step(); req0_valid = 1'b0;
        @(negedge clk); chk("ill_valid", W'(rsp_valid), 32'd1); chk("ill_err", W'(rsp_err), 32'd1);
        chk("ill_res", rsp_result, 32'd0); chk("ill_ctrl", W'(alu_ctrl), 32'd0);
        step();
        repeat (2) step();

        // Reset during EXEC discards the operation
        do_reset();
        req0_op = 4'd0; req0_a = 32'd3; req0_b = 32'd4; req0_valid = 1'b1;
        @(negedge clk); chk("rx_ready", W'(req0_ready), 32'd1);
        step(); req0_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rx_alu_a", alu_a, 32'd0); chk("rx_alu_b", alu_b, 32'd0);
        chk("rx_alu_ctrl", W'(alu_ctrl), 32'd0); chk("rx_rsp_valid", W'(rsp_valid), 32'd0);
        chk("rx_rsp_result", rsp_result, 32'd0); chk("rx_rsp_err", W'(rsp_err), 32'd0);
        chk("rx_rsp_zero", W'(rsp_zero), 32'd0); chk("rx_rsp_id", W'(rsp_id), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("rx_no_rsp", W'(rsp_valid), 32'd0);
            step();
        end

        // Fairness: six operations with both continuously valid
        do_reset();
        req0_op = 4'd0; req0_a = 32'd1;          req0_b = 32'd2;
        req1_op = 4'd10; req1_a = 32'h8000_0000; req1_b = 32'd4;
        run_ops(3, 3, 6);
        for (int k = 0; k < 6; k++) chk("fair_id", W'(r_id[k]), W'(k % 2));
        chk("fair_sra_res", r_res[1], 32'hF800_0000);
        chk("fair_add_res", r_res[2], 32'd3);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
